// File: rtl/block_select_encoder.sv
// Button front end for the cat-trap game: synchronise, debounce, move a cursor, encode it, strobe Down_b.
// Build option: define CURSOR_WRAP_EN to make cursor moves wrap at the board edges instead of saturating.

module block_select_encoder_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  input  logic sync_vld_i,
  output logic pulse_o
);
  // IDLE: released | CHK_PRESS: counting highs | PRESSED: held | CHK_REL: counting lows
  typedef enum logic [1:0] {IDLE, CHK_PRESS, PRESSED, CHK_REL} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          arm_q, arm_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      arm_q   <= arm_d;
    end
  end

  // A press still held across reset is ignored until a valid low sample re-arms the input.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    arm_d   = arm_q | (sync_vld_i & ~sync_i);
    case (state_q)
      IDLE: begin
        if (sync_i && arm_q) begin
          state_d = CHK_PRESS;
          cnt_d   = CW'(1);
        end
      end
      CHK_PRESS: begin
        if (!sync_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync_i) begin
          state_d = CHK_REL;
          cnt_d   = CW'(1);
        end
      end
      CHK_REL: begin
        if (sync_i) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse_o = pulse_q;
endmodule

module block_select_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROWS            = 6,
  parameter int COLS            = 7,
  parameter int INIT_ROW        = 3,
  parameter int INIT_COL        = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnC,
  output logic [7:0] Block_row,
  output logic [7:0] Block_col,
  output logic       Down_b,
  output logic [2:0] Cursor_row,
  output logic [2:0] Cursor_col
);
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  localparam logic [2:0] ROW_MAX  = 3'(ROWS - 1);
  localparam logic [2:0] COL_MAX  = 3'(COLS - 1);
  localparam logic [2:0] ROW_INIT = 3'(INIT_ROW);
  localparam logic [2:0] COL_INIT = 3'(INIT_COL);

`ifdef CURSOR_WRAP_EN
  localparam logic [2:0] ROW_U_EDGE = ROW_MAX;
  localparam logic [2:0] ROW_D_EDGE = 3'd0;
  localparam logic [2:0] COL_L_EDGE = COL_MAX;
  localparam logic [2:0] COL_R_EDGE = 3'd0;
`else
  localparam logic [2:0] ROW_U_EDGE = 3'd0;
  localparam logic [2:0] ROW_D_EDGE = ROW_MAX;
  localparam logic [2:0] COL_L_EDGE = 3'd0;
  localparam logic [2:0] COL_R_EDGE = COL_MAX;
`endif

  function automatic logic [7:0] encode(input logic [2:0] k);
    encode = (k == 3'd0) ? 8'h00 : (8'h01 << (k - 3'd1));
  endfunction

  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync2_q;
  logic [1:0] vld_q;
  logic [4:0] pulse;

  assign btn_raw = {BtnC, BtnR, BtnL, BtnD, BtnU};

  // vld_q marks when sync2_q holds real samples again after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_db
    block_select_encoder_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i     (Clk),
      .rst_i     (Reset),
      .sync_i    (sync2_q[i]),
      .sync_vld_i(vld_q[1]),
      .pulse_o   (pulse[i])
    );
  end

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [7:0] brow_q, bcol_q;
  logic       down_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case ({pulse[BTN_U], pulse[BTN_D]})
      2'b10:   row_d = (row_q == 3'd0)    ? ROW_U_EDGE : row_q - 3'd1;
      2'b01:   row_d = (row_q == ROW_MAX) ? ROW_D_EDGE : row_q + 3'd1;
      default: row_d = row_q;
    endcase
    case ({pulse[BTN_L], pulse[BTN_R]})
      2'b10:   col_d = (col_q == 3'd0)    ? COL_L_EDGE : col_q - 3'd1;
      2'b01:   col_d = (col_q == COL_MAX) ? COL_R_EDGE : col_q + 3'd1;
      default: col_d = col_q;
    endcase
  end

  // Encoding lags the cursor by one cycle, so Down_b always carries the pre-move code.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_q  <= ROW_INIT;
      col_q  <= COL_INIT;
      brow_q <= encode(ROW_INIT);
      bcol_q <= encode(COL_INIT);
      down_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      brow_q <= encode(row_q);
      bcol_q <= encode(col_q);
      down_q <= pulse[BTN_C];
    end
  end

  assign Block_row  = brow_q;
  assign Block_col  = bcol_q;
  assign Down_b     = down_q;
  assign Cursor_row = row_q;
  assign Cursor_col = col_q;
endmodule
